// File: rtl/display_pkg.sv
// Shared types and active-low segment patterns for the BCD scan display.
// Segment bit order is {g,f,e,d,c,b,a}.
package display_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_digit_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD-to-7-segment decoder; non-decimal nibbles and forced
// dash both show a dash.
module seven_seg_decoder
  import display_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       dash_en,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (!dash_en && digit <= 4'd9) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures a BCD result plus sign and scans it onto a multiplexed active-low
// 7-segment display with leading-zero blanking and per-slot anti-ghost blanking.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 5,
  parameter int AN_WIDTH     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    neg,
  output logic [AN_WIDTH-1:0]     an,
  output seg_t                    seg,
  output logic                    dp,
  output logic                    display_valid
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] SIGN_IDX  = IW'(NUM_DIGITS);
  localparam logic [AN_WIDTH-1:0] AN_ONE = AN_WIDTH'(1);

  logic [PW-1:0]                    pre;
  logic [IW-1:0]                    idx;
  bcd_digit_t [NUM_DIGITS-1:0]      disp_q;
  logic                             neg_q;

  logic [IW-1:0]                    msd;
  bcd_digit_t                       cur;
  logic                             sign_slot, lit, drive;
  seg_t                             dec_seg, seg_nxt;
  logic [AN_WIDTH-1:0]              an_nxt;

  // Scan timebase: prescaler wraps every slot, index walks digits then sign.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == SIGN_IDX) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q        <= '0;
      neg_q         <= 1'b0;
      display_valid <= 1'b0;
    end else if (load) begin
      disp_q        <= bcd_in;
      neg_q         <= neg;
      display_valid <= 1'b1;
    end
  end

  // Highest nonzero digit wins; invalid nibbles count as nonzero.
  always_comb begin
    msd = '0;
    cur = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_q[i] != 4'd0) msd = IW'(i);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IW'(i)) cur = disp_q[i];
  end

  assign sign_slot = (idx == SIGN_IDX);
  assign lit       = sign_slot ? neg_q : (idx <= msd);
  assign drive     = (pre >= BLANK_END);

  seven_seg_decoder u_dec (
    .digit   (cur),
    .dash_en (sign_slot),
    .seg     (dec_seg)
  );

  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    if (display_valid && drive && lit) begin
      an_nxt  = ~(AN_ONE << idx);
      seg_nxt = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a cycle-level expected-output scoreboard.
module tb_bcd_display_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        neg = 1'b0;
  logic [19:0] bcd_in = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, display_valid;

  int total = 0;
  int bad = 0;

  logic [6:0] dec [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [7:0] an_tab  [5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
  logic [6:0] seg_tab [5] = '{7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  int          m_pre, m_idx;
  logic [19:0] m_disp;
  logic        m_neg, m_valid;
  logic [7:0]  q_an [$];
  logic [6:0]  q_seg [$];
  logic [7:0]  last_an;
  logic [6:0]  last_seg;

  bcd_display_scan #(.NUM_DIGITS(5), .AN_WIDTH(8), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .neg(neg),
    .an(an), .seg(seg), .dp(dp), .display_valid(display_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_disp = '0; m_neg = 1'b0; m_valid = 1'b0;
    q_an.delete(); q_seg.delete();
  endtask

  function automatic void expect_out(output logic [7:0] ean, output logic [6:0] eseg);
    int top;
    logic found, lit;
    logic [3:0] nib;
    top = 0; found = 1'b0;
    for (int i = 4; i >= 1; i--)
      if (!found && m_disp[4*i +: 4] != 4'd0) begin top = i; found = 1'b1; end
    lit  = (m_idx == 5) ? m_neg : (m_idx <= top);
    ean  = 8'hFF;
    eseg = 7'h7F;
    if (m_valid && m_pre >= 1 && lit) begin
      ean = ~(8'h01 << m_idx);
      if (m_idx == 5) eseg = 7'b0111111;
      else begin
        nib  = m_disp[4*m_idx +: 4];
        eseg = (nib > 4'd9) ? 7'b0111111 : dec[nib];
      end
    end
  endfunction

  // One clock: queue the expected output for the current state, step, then compare.
  task automatic cyc();
    logic [7:0] ea;
    logic [6:0] es;
    expect_out(ea, es);
    q_an.push_back(ea);
    q_seg.push_back(es);
    @(posedge clk);
    if (load) begin m_disp = bcd_in; m_neg = neg; m_valid = 1'b1; end
    if (m_pre == 3) begin m_pre = 0; m_idx = (m_idx == 5) ? 0 : m_idx + 1; end
    else m_pre++;
    #1;
    last_an  = an;
    last_seg = seg;
    chk("an", an, q_an.pop_front());
    chk("seg", seg, q_seg.pop_front());
    chk("valid", display_valid, m_valid);
    chk("dp", dp, 1);
  endtask

  task automatic load_val(input logic [19:0] v, input logic s);
    bcd_in = v; neg = s; load = 1'b1;
    cyc();
    load = 1'b0; bcd_in = 20'hFFFFF; neg = ~s;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_valid", display_valid, 0);
    chk("rst_dp", dp, 1);
    reset = 1'b1;

    // Idle after reset: dark throughout
    repeat (100) cyc();

    // 12345, positive: one aligned scan checked against fixed tables
    load_val(20'h12345, 1'b0);
    for (int k = 0; k < 30 && !(m_idx == 0 && m_pre == 0); k++) cyc();
    for (int s = 0; s < 6; s++)
      for (int p = 0; p < 4; p++) begin
        cyc();
        chk("scan_an", last_an, (p == 0 || s == 5) ? 8'hFF : an_tab[s]);
        chk("scan_seg", last_seg, (p == 0 || s == 5) ? 7'h7F : seg_tab[s]);
      end

    // Leading-zero blanking and all-zero value
    load_val(20'h00042, 1'b0);
    repeat (30) cyc();
    load_val(20'h00000, 1'b0);
    repeat (30) cyc();

    // Negative single digit: sign slot lit with dash
    load_val(20'h00007, 1'b1);
    repeat (30) cyc();

    // Invalid nibble shows dash and counts for blanking
    load_val(20'h0A001, 1'b0);
    repeat (30) cyc();

    // Mid-slot async reset goes dark immediately
    repeat (5) cyc();
    #2 reset = 1'b0;
    #1;
    chk("mid_an", an, 8'hFF);
    chk("mid_seg", seg, 7'h7F);
    chk("mid_valid", display_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back loads: last value wins
    bcd_in = 20'h11111; neg = 1'b0; load = 1'b1;
    cyc();
    bcd_in = 20'h99999;
    cyc();
    load = 1'b0; bcd_in = 20'h00000;
    repeat (30) begin
      cyc();
      if (last_an != 8'hFF) chk("nines", last_seg, 7'b0010000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
